// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, multiplier FSM states and iteration count.
// Defining MUL_BOOTH_RADIX4_EN selects the radix-4 Booth datapath.
package alu_pkg;

    localparam logic [3:0] OP_MUL = 4'h1;

`ifdef MUL_BOOTH_RADIX4_EN
    localparam bit RADIX4_EN = 1'b1;
`else
    localparam bit RADIX4_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operands are widened by two bits so every signed/unsigned product is exact.
    function automatic int iter_count(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add the recoded multiple of M to A,
// then arithmetic right shift of {A, q, q_1} by one (radix-2) or two (radix-4).
module booth_step #(
    parameter int N      = 18,
    parameter bit RADIX4 = 1'b0,
    parameter int AW     = RADIX4 ? N + 1 : N
) (
    input  logic [AW-1:0] a_i,
    input  logic [N-1:0]  q_i,
    input  logic          q1_i,
    input  logic [AW-1:0] m_i,
    input  logic [AW-1:0] m_neg_i,
    output logic [AW-1:0] a_o,
    output logic [N-1:0]  q_o,
    output logic          q1_o
);

    logic [AW-1:0] sum;

    generate
        if (RADIX4) begin : g_radix4
            // A carries one spare bit so the +-2M digits cannot overflow.
            always_comb begin
                sum = a_i;
                case ({q_i[1:0], q1_i})
                    3'b001, 3'b010: sum = a_i + m_i;
                    3'b011:         sum = a_i + (m_i << 1);
                    3'b100:         sum = a_i + (m_neg_i << 1);
                    3'b101, 3'b110: sum = a_i + m_neg_i;
                    default:        sum = a_i;
                endcase
                a_o  = {{2{sum[AW-1]}}, sum[AW-1:2]};
                q_o  = {sum[1:0], q_i[N-1:2]};
                q1_o = q_i[1];
            end
        end else begin : g_radix2
            always_comb begin
                sum = a_i;
                case ({q_i[0], q1_i})
                    2'b10:   sum = a_i + m_neg_i;
                    2'b01:   sum = a_i + m_i;
                    default: sum = a_i;
                endcase
                a_o  = {sum[AW-1], sum[AW-1:1]};
                q_o  = {sum[0], q_i[N-1:1]};
                q1_o = q_i[0];
            end
        end
    endgenerate

endmodule

// File: rtl/mul_booth.sv
// Iterative Booth multiplier for the calculator ALU (signed or unsigned operands).
// Radix-2 by default; radix-4 when MUL_BOOTH_RADIX4_EN is defined.
module mul_booth
    import alu_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] OP_CODE = OP_MUL
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [3:0]         dtype,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N    = WIDTH + 2;
    localparam int AW   = RADIX4_EN ? N + 1 : N;
    localparam int ITER = iter_count(WIDTH, RADIX4_EN);
    localparam int CW   = $clog2(ITER);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      a_q, a_d;
    logic [N-1:0]       q_q, q_d;
    logic               q1_q, q1_d;
    logic [AW-1:0]      m_q, m_d;
    logic [AW-1:0]      m_neg_q, m_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [AW-1:0]      m_ext;
    logic [N-1:0]       q_ext;
    logic [AW-1:0]      a_nx;
    logic [N-1:0]       q_nx;
    logic               q1_nx;
    logic               unused_a;

    assign m_ext    = {{(AW-WIDTH){is_signed & M[WIDTH-1]}}, M};
    assign q_ext    = {{(N-WIDTH){is_signed & Q[WIDTH-1]}}, Q};
    // Top bits of the 2N-bit product are pure sign extension of the 2*WIDTH result.
    assign unused_a = ^a_nx[AW-1:WIDTH-2];

    booth_step #(
        .N      (N),
        .RADIX4 (RADIX4_EN),
        .AW     (AW)
    ) u_step (
        .a_i     (a_q),
        .q_i     (q_q),
        .q1_i    (q1_q),
        .m_i     (m_q),
        .m_neg_i (m_neg_q),
        .a_o     (a_nx),
        .q_o     (q_nx),
        .q1_o    (q1_nx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        m_neg_d  = m_neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && (dtype == OP_CODE)) begin
                    state_d = RUN;
                    cnt_d   = CW'(ITER - 1);
                    a_d     = '0;
                    q_d     = q_ext;
                    q1_d    = 1'b0;
                    m_d     = m_ext;
                    m_neg_d = -m_ext;
                end
            end
            RUN: begin
                a_d  = a_nx;
                q_d  = q_nx;
                q1_d = q1_nx;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = {a_nx[WIDTH-3:0], q_nx};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            m_neg_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            m_neg_q  <= m_neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_booth.sv
// Self-checking bench for mul_booth at WIDTH=16 and WIDTH=8, directed cases
// followed by a continuous-start random run against an arithmetic reference.
module tb_mul_booth;

`ifdef MUL_BOOTH_RADIX4_EN
    localparam bit R4 = 1'b1;
`else
    localparam bit R4 = 1'b0;
`endif
    localparam int ITER16 = R4 ? 9 : 18;
    localparam int ITER8  = R4 ? 5 : 10;
    localparam int NCYC   = 30000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;

    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [3:0]  dtype16 = 4'h0;
    logic [15:0] m16 = '0, q16 = '0;
    logic        busy16, done16;
    logic [31:0] res16;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [3:0]  dtype8 = 4'h0;
    logic [7:0]  m8 = '0, q8 = '0;
    logic        busy8, done8;
    logic [15:0] res8;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_booth #(.WIDTH(16), .OP_CODE(4'h1)) dut (
        .clk(clk), .n_rst(n_rst), .start(start16), .dtype(dtype16),
        .is_signed(sgn16), .M(m16), .Q(q16),
        .busy(busy16), .done(done16), .result(res16)
    );

    mul_booth #(.WIDTH(8), .OP_CODE(4'h1)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .dtype(dtype8),
        .is_signed(sgn8), .M(m8), .Q(q8),
        .busy(busy8), .done(done8), .result(res8)
    );

    always #5 clk = ~clk;

    // Exact product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] m,
                                            input logic [31:0] q, input bit s);
        longint a, b, p, mask;
        a = longint'(m);
        b = longint'(q);
        if (s && m[w-1]) a = a - (longint'(1) << w);
        if (s && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the 16-bit instance; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q,
                                 input bit s, input logic [3:0] dt);
        m16 = m; q16 = q; sgn16 = s; dtype16 = dt; start16 = 1'b1;
        tick();
        start16 = 1'b0;
    endtask

    // Wait for done on the 16-bit instance and check latency, result and pulse width.
    task automatic finish16(input string tag, input logic [31:0] exp);
        int cyc = 0;
        while (!done16 && cyc < ITER16 + 8) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(ITER16));
        checkOutput({tag, "_result"}, 64'(res16), 64'(exp));
        checkOutput({tag, "_busy_at_done"}, 64'(busy16), 64'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(done16), 64'd0);
    endtask

    logic [31:0] exp16_q[$];
    logic [15:0] exp8_q[$];

    initial begin
        logic [31:0] last16;
        logic [31:0] e;
        int          extra;
        int          acc16, acc8, ops16, ops8, last_acc16, last_acc8, cyc;
        bit          pb16, pb8;

        #12;
        checkOutput("reset_busy", 64'(busy16), 64'd0);
        checkOutput("reset_done", 64'(done16), 64'd0);
        checkOutput("reset_result", 64'(res16), 64'd0);
        checkOutput("reset_result8", 64'(res8), 64'd0);
        n_rst = 1'b1;
        tick();

        applyStimulus(16'hFFFD, 16'h0005, 1'b1, 4'h1);
        checkOutput("signed_busy", 64'(busy16), 64'd1);
        finish16("signed", 32'hFFFF_FFF1);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 4'h1);
        finish16("unsigned_max", 32'hFFFE_0001);

        applyStimulus(16'h8000, 16'h8000, 1'b1, 4'h1);
        finish16("signed_min", 32'h4000_0000);
        last16 = 32'h4000_0000;

        // Wrong opcode with start held must leave the block idle.
        m16 = 16'h0003; q16 = 16'h0004; sgn16 = 1'b0; dtype16 = 4'h2; start16 = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy16 || done16) extra++;
        end
        start16 = 1'b0;
        checkOutput("ignored_dtype_activity", 64'(extra), 64'd0);
        checkOutput("ignored_dtype_result", 64'(res16), 64'(last16));

        // Start re-pulsed mid-run with different operands.
        applyStimulus(16'h1234, 16'h0056, 1'b0, 4'h1);
        tick(); tick();
        m16 = 16'hFFFF; q16 = 16'h7FFF; sgn16 = 1'b1; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        e = 32'(ref_mul(16, 32'h1234, 32'h0056, 1'b0));
        extra = 0;
        while (!done16 && extra < ITER16 + 8) begin
            tick();
            extra++;
        end
        checkOutput("midrun_result", 64'(res16), 64'(e));
        extra = 0;
        for (int i = 0; i < ITER16 + 4; i++) begin
            tick();
            if (busy16 || done16) extra++;
        end
        checkOutput("midrun_no_second_op", 64'(extra), 64'd0);

        // Asynchronous reset during RUN clears outputs without waiting for a clock.
        applyStimulus(16'h0101, 16'h0033, 1'b0, 4'h1);
        for (int i = 0; i < 4; i++) tick();
        #2 n_rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy16), 64'd0);
        checkOutput("rst_mid_result", 64'(res16), 64'd0);
        #1 n_rst = 1'b1;
        tick();
        checkOutput("rst_after_done", 64'(done16), 64'd0);
        applyStimulus(16'd7, 16'd6, 1'b0, 4'h1);
        finish16("post_reset", 32'h0000_002A);

        // Narrow instance.
        m8 = 8'h80; q8 = 8'h7F; sgn8 = 1'b1; dtype8 = 4'h1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        extra = 0;
        while (!done8 && extra < ITER8 + 8) begin
            tick();
            extra++;
        end
        checkOutput("narrow_latency", 64'(extra), 64'(ITER8));
        checkOutput("narrow_result", 64'(res8), 64'h0000_C080);
        tick();

        // Random run with start held high on both instances.
        m16 = 16'($urandom); q16 = 16'($urandom); sgn16 = 1'($urandom);
        m8 = 8'($urandom); q8 = 8'($urandom); sgn8 = 1'($urandom);
        dtype16 = 4'h1; dtype8 = 4'h1; start16 = 1'b1; start8 = 1'b1;
        pb16 = 1'b0; pb8 = 1'b0; ops16 = 0; ops8 = 0; acc16 = 0; acc8 = 0;
        last_acc16 = 0; last_acc8 = 0;
        for (cyc = 1; cyc <= NCYC; cyc++) begin
            tick();
            if (busy16 && !pb16) begin
                exp16_q.push_back(32'(ref_mul(16, 32'(m16), 32'(q16), sgn16)));
                if (acc16 > 0) checkOutput("rand16_spacing", 64'(cyc - last_acc16), 64'(ITER16 + 2));
                acc16++;
                last_acc16 = cyc;
                m16 = 16'($urandom); q16 = 16'($urandom); sgn16 = 1'($urandom);
            end
            if (done16) begin
                checkOutput("rand16_pending", 64'(exp16_q.size() > 0), 64'd1);
                if (exp16_q.size() > 0) checkOutput("rand16_result", 64'(res16), 64'(exp16_q.pop_front()));
                checkOutput("rand16_busy_done", 64'(busy16), 64'd0);
                ops16++;
            end
            pb16 = busy16;
            if (busy8 && !pb8) begin
                exp8_q.push_back(16'(ref_mul(8, 32'(m8), 32'(q8), sgn8)));
                if (acc8 > 0) checkOutput("rand8_spacing", 64'(cyc - last_acc8), 64'(ITER8 + 2));
                acc8++;
                last_acc8 = cyc;
                m8 = 8'($urandom); q8 = 8'($urandom); sgn8 = 1'($urandom);
            end
            if (done8) begin
                checkOutput("rand8_pending", 64'(exp8_q.size() > 0), 64'd1);
                if (exp8_q.size() > 0) checkOutput("rand8_result", 64'(res8), 64'(exp8_q.pop_front()));
                ops8++;
            end
            pb8 = busy8;
        end
        start16 = 1'b0;
        start8 = 1'b0;
        checkOutput("rand16_throughput", 64'(ops16 >= NCYC / (ITER16 + 2) - 2), 64'd1);
        checkOutput("rand8_throughput", 64'(ops8 >= NCYC / (ITER8 + 2) - 2), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
